// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_engine
// Description : SD card CMD-line sequencer. Generates the SD clock, sends a
//               48-bit command frame with CRC7, waits for and captures a
//               48-bit response, and checks its framing and CRC.
//   clk, reset_n            system clock, async active-low reset
//   cmd_start/index/arg     one-cycle request with command fields
//   resp_type               00 none, 01/11 R1-style with CRC, 10 R3 no CRC
//   busy, done              handshake (done is a one-cycle pulse)
//   resp, resp_index        response argument and index fields
//   status                  [2] timeout, [1] crc_err, [0] frame_err
//   sd_clk, sd_cmd_o/oe/i   card-side clock and CMD line
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_engine #(
    parameter int CLK_DIV      = 125,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    output logic        busy,
    output logic        done,
    output logic [31:0] resp,
    output logic [5:0]  resp_index,
    output logic [2:0]  status,
    output logic        sd_clk,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_i
);

    localparam logic [9:0]  c_div_last = 10'(CLK_DIV - 1);
    localparam logic [15:0] c_to_last  = 16'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_RECV = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      r_state;
    logic [9:0]  r_div_cnt;
    logic [47:0] r_tx;
    logic [46:0] r_rx;
    logic [5:0]  r_bit_cnt;
    logic [15:0] r_to_cnt;
    logic [1:0]  r_resp_type;

    logic        w_div_tc;
    logic        w_fall_en;
    logic        w_rise_en;
    logic [6:0]  w_tx_crc;
    logic [47:0] w_rx_next;
    logic [6:0]  w_rx_crc;
    logic        w_frame_err;
    logic        w_crc_err;

    // CRC7, polynomial x^7+x^3+1, zero seed, MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    // Free-running SD clock divider; strobes mark the toggle cycle.
    assign w_div_tc  = (r_div_cnt == c_div_last);
    assign w_fall_en = w_div_tc & sd_clk;
    assign w_rise_en = w_div_tc & ~sd_clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= 10'd0;
            sd_clk    <= 1'b0;
        end else if (w_div_tc) begin
            r_div_cnt <= 10'd0;
            sd_clk    <= ~sd_clk;
        end else begin
            r_div_cnt <= r_div_cnt + 10'd1;
        end
    end

    assign w_tx_crc = crc7({2'b01, cmd_index, cmd_arg});

    // Full received frame including the bit sampled this cycle; only
    // meaningful on the final RECV sample.
    assign w_rx_next   = {r_rx, sd_cmd_i};
    assign w_rx_crc    = crc7(w_rx_next[47:8]);
    assign w_frame_err = w_rx_next[46] | ~w_rx_next[0];
    assign w_crc_err   = (r_resp_type != 2'b10) && (w_rx_crc != w_rx_next[7:1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tx        <= 48'd0;
            r_rx        <= 47'd0;
            r_bit_cnt   <= 6'd0;
            r_to_cnt    <= 16'd0;
            r_resp_type <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            resp        <= 32'd0;
            resp_index  <= 6'd0;
            status      <= 3'd0;
            sd_cmd_o    <= 1'b1;
            sd_cmd_oe   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    sd_cmd_o  <= 1'b1;
                    sd_cmd_oe <= 1'b0;
                    if (cmd_start) begin
                        r_tx        <= {2'b01, cmd_index, cmd_arg, w_tx_crc, 1'b1};
                        r_resp_type <= resp_type;
                        r_bit_cnt   <= 6'd0;
                        status      <= 3'd0;
                        busy        <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_fall_en) begin
                        if (r_bit_cnt == 6'd48) begin
                            // End bit has had its full period; release CMD.
                            sd_cmd_o  <= 1'b1;
                            sd_cmd_oe <= 1'b0;
                            r_bit_cnt <= 6'd0;
                            r_to_cnt  <= 16'd0;
                            r_state   <= (r_resp_type == 2'b00) ? S_GAP : S_WAIT;
                        end else begin
                            sd_cmd_o  <= r_tx[47];
                            sd_cmd_oe <= 1'b1;
                            r_tx      <= {r_tx[46:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_rise_en) begin
                        if (!sd_cmd_i) begin
                            r_rx      <= 47'd0;   // start bit already seen
                            r_bit_cnt <= 6'd1;
                            r_state   <= S_RECV;
                        end else if (r_to_cnt == c_to_last) begin
                            status     <= 3'b100;
                            resp       <= 32'd0;
                            resp_index <= 6'd0;
                            r_bit_cnt  <= 6'd0;
                            r_state    <= S_GAP;
                        end else begin
                            r_to_cnt <= r_to_cnt + 16'd1;
                        end
                    end
                end
                S_RECV: begin
                    if (w_rise_en) begin
                        r_rx <= w_rx_next[46:0];
                        if (r_bit_cnt == 6'd47) begin
                            status     <= {1'b0, w_crc_err, w_frame_err};
                            resp       <= w_rx_next[39:8];
                            resp_index <= w_rx_next[45:40];
                            r_bit_cnt  <= 6'd0;
                            r_state    <= S_GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_rise_en) begin
                        if (r_bit_cnt == 6'd7) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    sd_cmd_o  <= 1'b1;
                    sd_cmd_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sd_cmd_engine
// Description : Directed self-checking bench for sd_cmd_engine with a small
//               card model that captures host frames and replies on CMD.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_engine;

    localparam int CLK_DIV      = 2;
    localparam int RESP_TIMEOUT = 64;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg   = 32'd0;
    logic [1:0]  resp_type = 2'b00;
    logic        busy;
    logic        done;
    logic [31:0] resp;
    logic [5:0]  resp_index;
    logic [2:0]  status;
    logic        sd_clk;
    logic        sd_cmd_o;
    logic        sd_cmd_oe;
    logic        sd_cmd_i;

    logic        card_drive = 1'b0;
    logic        card_bit   = 1'b1;
    logic [47:0] card_frame = 48'd0;
    event        card_go;

    assign sd_cmd_i = card_drive ? card_bit : 1'b1;

    sd_cmd_engine #(
        .CLK_DIV      (CLK_DIV),
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_start  (cmd_start),
        .cmd_index  (cmd_index),
        .cmd_arg    (cmd_arg),
        .resp_type  (resp_type),
        .busy       (busy),
        .done       (done),
        .resp       (resp),
        .resp_index (resp_index),
        .status     (status),
        .sd_clk     (sd_clk),
        .sd_cmd_o   (sd_cmd_o),
        .sd_cmd_oe  (sd_cmd_oe),
        .sd_cmd_i   (sd_cmd_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Card side: capture host bits on rising SD clock, count rising edges.
    logic [47:0] cap       = 48'd0;
    int          cap_n     = 0;
    int          rise_cnt  = 0;
    int          rise_mark = 0;

    always @(posedge sd_clk) begin
        rise_cnt <= rise_cnt + 1;
        if (sd_cmd_oe) begin
            cap   <= {cap[46:0], sd_cmd_o};
            cap_n <= cap_n + 1;
        end
    end

    always @(negedge sd_cmd_oe) rise_mark <= rise_cnt;

    // Card reply: starts right after the host releases CMD, one bit per
    // SD clock period, changed just after each falling edge.
    initial begin
        forever begin
            @(card_go);
            @(negedge sd_cmd_oe);
            #1;
            card_drive = 1'b1;
            for (int k = 47; k >= 0; k--) begin
                card_bit = card_frame[k];
                @(negedge sd_clk);
                #1;
            end
            card_drive = 1'b0;
            card_bit   = 1'b1;
        end
    end

    task automatic do_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] rt, input logic [47:0] exp_frame,
                          input logic [2:0] exp_status, input int exp_rises, input int inject_at);
        int  n0;
        bit  seen;
        n0 = cap_n;
        @(negedge clk);
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        seen = 1'b0;
        for (int cyc = 1; cyc <= 5000 && !seen; cyc++) begin
            if (cyc == inject_at) begin
                cmd_index = 6'd8;
                cmd_arg   = 32'h0000_01AA;
                resp_type = 2'b01;
                cmd_start = 1'b1;
            end else begin
                cmd_start = 1'b0;
            end
            @(negedge clk);
            seen = done;
        end
        cmd_start = 1'b0;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, " busy_in_done"}, 64'(busy), 64'd0);
            check({tag, " status"}, 64'(status), 64'(exp_status));
            check({tag, " frame"}, 64'(cap), 64'(exp_frame));
            check({tag, " frame_bits"}, 64'(cap_n - n0), 64'd48);
            check({tag, " rises_after_release"}, 64'(rise_cnt - rise_mark), 64'(exp_rises));
            check({tag, " oe_released"}, 64'(sd_cmd_oe), 64'd0);
            // A request in the done cycle must be dropped.
            cmd_start = 1'b1;
            @(negedge clk);
            cmd_start = 1'b0;
            check({tag, " done_one_cycle"}, 64'(done), 64'd0);
            check({tag, " start_in_done_dropped"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset sd_clk", 64'(sd_clk), 64'd0);
        check("reset sd_cmd_o", 64'(sd_cmd_o), 64'd1);
        check("reset sd_cmd_oe", 64'(sd_cmd_oe), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset resp", 64'(resp), 64'd0);
        check("reset resp_index", 64'(resp_index), 64'd0);
        check("reset status", 64'(status), 64'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // CMD0, no response: GAP follows release directly.
        do_cmd("cmd0", 6'd0, 32'h0, 2'b00, 48'h40_0000_0000_95, 3'b000, 8, 0);

        // CMD8 with a clean R7 reply.
        card_frame = 48'h08_0000_01AA_13;
        -> card_go;
        do_cmd("cmd8", 6'd8, 32'h0000_01AA, 2'b01, 48'h48_0000_01AA_87, 3'b000, 56, 0);
        check("cmd8 resp", 64'(resp), 64'h0000_01AA);
        check("cmd8 resp_index", 64'(resp_index), 64'd8);

        // Bit 20 flipped: CRC error only.
        card_frame = 48'h08_0000_01AA_13 ^ 48'h00_0000_1000_00;
        -> card_go;
        do_cmd("cmd8_crc", 6'd8, 32'h0000_01AA, 2'b01, 48'h48_0000_01AA_87, 3'b010, 56, 0);

        // End bit 0: framing error only.
        card_frame = 48'h08_0000_01AA_12;
        -> card_go;
        do_cmd("cmd8_end", 6'd8, 32'h0000_01AA, 2'b01, 48'h48_0000_01AA_87, 3'b001, 56, 0);

        // CMD58, R3: CRC field is all ones and must not be checked.
        card_frame = 48'h3F_80FF_8000_FF;
        -> card_go;
        do_cmd("cmd58", 6'd58, 32'h0, 2'b10, 48'h7A_0000_0000_FD, 3'b000, 56, 0);
        check("cmd58 resp", 64'(resp), 64'h80FF_8000);
        check("cmd58 resp_index", 64'(resp_index), 64'h3F);

        // CMD55 with no card reply: timeout after RESP_TIMEOUT rises, then GAP.
        do_cmd("cmd55_to", 6'd55, 32'h0, 2'b01, 48'h77_0000_0000_65, 3'b100, RESP_TIMEOUT + 8, 0);
        check("cmd55_to resp", 64'(resp), 64'd0);
        check("cmd55_to resp_index", 64'(resp_index), 64'd0);

        // resp_type 11 behaves as 01: bad CRC is flagged.
        card_frame = 48'h08_0000_01AA_13 ^ 48'h00_0000_1000_00;
        -> card_go;
        do_cmd("cmd8_rt11", 6'd8, 32'h0000_01AA, 2'b11, 48'h48_0000_01AA_87, 3'b010, 56, 0);

        // Request mid-SEND is ignored: frame and no-response path unchanged.
        do_cmd("cmd0_inject", 6'd0, 32'h0, 2'b00, 48'h40_0000_0000_95, 3'b000, 8, 30);

        // Asynchronous reset in the middle of SEND.
        @(negedge clk);
        cmd_index = 6'd8;
        cmd_arg   = 32'h0000_01AA;
        resp_type = 2'b01;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        repeat (40) @(negedge clk);
        check("midsend oe_driving", 64'(sd_cmd_oe), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midsend_rst oe", 64'(sd_cmd_oe), 64'd0);
        check("midsend_rst busy", 64'(busy), 64'd0);
        check("midsend_rst sd_clk", 64'(sd_clk), 64'd0);
        check("midsend_rst sd_cmd_o", 64'(sd_cmd_o), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        do_cmd("cmd0_after_rst", 6'd0, 32'h0, 2'b00, 48'h40_0000_0000_95, 3'b000, 8, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
